// File: rtl/dcache_2way_wb_if.sv
// dcache_2way_wb_if: CPU load/store and memory-beat signals of the 2-way write-back data cache
//   slave  : cache side  (receives CPU requests, drives memory beats)
//   master : environment (drives CPU requests, answers memory beats)
interface dcache_2way_wb_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  cpu_req;
   logic                  cpu_we;
   logic [ADDR_WIDTH-1:0] cpu_addr;
   logic [DATA_WIDTH-1:0] cpu_wdata;
   logic [DATA_WIDTH-1:0] cpu_rdata;
   logic                  cpu_ready;
   logic                  hit_out;
   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_ack;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
      output cpu_rdata, cpu_ready, hit_out, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
      input  cpu_rdata, cpu_ready, hit_out, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/dcache_2way_wb.sv
// dcache_2way_wb: 2-way set-associative, write-back, write-allocate data cache with LRU
// replacement, dirty-line writeback and burst refill over a req/ack memory handshake.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   bus (slave)       CPU side: cpu_req/we/addr/wdata in, cpu_rdata/cpu_ready/hit_out out
//                     memory side: mem_req/we/addr/wdata out, mem_rdata/mem_ack in
//   o_hit_count       hit counter   (live only with DCACHE_PERF_CNT_EN defined, else 0)
//   o_miss_count      miss counter  (live only with DCACHE_PERF_CNT_EN defined, else 0)
// Optional feature macro: DCACHE_PERF_CNT_EN
module dcache_2way_wb #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int SETS       = 8,
   parameter int WORDS      = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   dcache_2way_wb_if.slave    bus,
   output logic [31:0]        o_hit_count,
   output logic [31:0]        o_miss_count
);
   localparam int OFF_W = $clog2(DATA_WIDTH / 8);
   localparam int WRD_W = $clog2(WORDS);
   localparam int SET_W = $clog2(SETS);
   localparam int TAG_W = ADDR_WIDTH - SET_W - WRD_W - OFF_W;

   typedef enum logic [1:0] {IDLE, WBACK, REFILL} state_t;

   state_t                r_state;
   logic [DATA_WIDTH-1:0] r_data  [2][SETS][WORDS];
   logic [TAG_W-1:0]      r_tag   [2][SETS];
   logic [SETS-1:0]       r_valid [2];
   logic [SETS-1:0]       r_dirty [2];
   logic [SETS-1:0]       r_lru;
   logic                  r_vic;
   logic [SET_W-1:0]      r_set;
   logic [TAG_W-1:0]      r_mtag;
   logic [WRD_W-1:0]      r_beat;
   logic                  r_mem_req;
   logic                  r_mem_we;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [DATA_WIDTH-1:0] r_mem_wdata;

   logic [TAG_W-1:0]      w_tag;
   logic [SET_W-1:0]      w_set;
   logic [WRD_W-1:0]      w_word;
   logic                  w_hit0;
   logic                  w_hit1;
   logic                  w_hit;
   logic                  w_miss;
   logic                  w_way;
   logic                  w_vic;
   logic                  w_vdirty;
   logic                  w_last;
   logic [WRD_W-1:0]      w_nbeat;
   logic                  w_unused_ok;

   function automatic logic [ADDR_WIDTH-1:0] f_addr(input logic [TAG_W-1:0] t,
                                                    input logic [SET_W-1:0] s,
                                                    input logic [WRD_W-1:0] b);
      return ADDR_WIDTH'({t, s, b}) << OFF_W;
   endfunction

   assign w_tag       = bus.cpu_addr[ADDR_WIDTH-1 -: TAG_W];
   assign w_set       = bus.cpu_addr[OFF_W+WRD_W +: SET_W];
   assign w_word      = bus.cpu_addr[OFF_W +: WRD_W];
   assign w_unused_ok = ^(bus.cpu_addr & ADDR_WIDTH'((1 << OFF_W) - 1));
   assign w_hit0      = r_valid[0][w_set] && (r_tag[0][w_set] == w_tag);
   assign w_hit1      = r_valid[1][w_set] && (r_tag[1][w_set] == w_tag);
   assign w_hit       = (r_state == IDLE) && bus.cpu_req && (w_hit0 || w_hit1);
   assign w_miss      = (r_state == IDLE) && bus.cpu_req && !(w_hit0 || w_hit1);
   assign w_way       = !w_hit0;
   // Fill an empty way first; only a full set consults the LRU bit.
   assign w_vic       = !r_valid[0][w_set] ? 1'b0 : !r_valid[1][w_set] ? 1'b1 : r_lru[w_set];
   assign w_vdirty    = r_valid[w_vic][w_set] && r_dirty[w_vic][w_set];
   assign w_last      = r_beat == WRD_W'(WORDS - 1);
   assign w_nbeat     = r_beat + 1'b1;

   assign bus.cpu_rdata = r_data[w_way][w_set][w_word];
   assign bus.cpu_ready = w_hit;
   assign bus.hit_out   = w_hit;
   assign bus.mem_req   = r_mem_req;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;

   // The miss address is captured at the miss so the fill completes even if the CPU lets go.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_valid     <= '{default: '0};
         r_dirty     <= '{default: '0};
         r_lru       <= '0;
         r_vic       <= 1'b0;
         r_set       <= '0;
         r_mtag      <= '0;
         r_beat      <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_hit) begin
                  r_lru[w_set] <= ~w_way;
                  if (bus.cpu_we) r_dirty[w_way][w_set] <= 1'b1;
               end else if (w_miss) begin
                  r_state     <= w_vdirty ? WBACK : REFILL;
                  r_vic       <= w_vic;
                  r_set       <= w_set;
                  r_mtag      <= w_tag;
                  r_beat      <= '0;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= w_vdirty;
                  r_mem_addr  <= w_vdirty ? f_addr(r_tag[w_vic][w_set], w_set, '0) : f_addr(w_tag, w_set, '0);
                  r_mem_wdata <= r_data[w_vic][w_set][0];
               end
            end
            WBACK: begin
               if (bus.mem_ack) begin
                  r_beat      <= w_nbeat;
                  r_mem_addr  <= w_last ? f_addr(r_mtag, r_set, '0) : f_addr(r_tag[r_vic][r_set], r_set, w_nbeat);
                  r_mem_wdata <= r_data[r_vic][r_set][w_nbeat];
                  if (w_last) begin
                     r_state               <= REFILL;
                     r_mem_we              <= 1'b0;
                     r_dirty[r_vic][r_set] <= 1'b0;
                  end
               end
            end
            REFILL: begin
               if (bus.mem_ack) begin
                  r_beat     <= w_nbeat;
                  r_mem_addr <= f_addr(r_mtag, r_set, w_nbeat);
                  if (w_last) begin
                     r_state               <= IDLE;
                     r_mem_req             <= 1'b0;
                     r_valid[r_vic][r_set] <= 1'b1;
                     r_dirty[r_vic][r_set] <= 1'b0;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Data and tag storage carry no reset; validity alone decides what they mean.
   always_ff @(posedge clk) begin
      if (w_hit && bus.cpu_we) r_data[w_way][w_set][w_word] <= bus.cpu_wdata;
      if (r_state == REFILL && bus.mem_ack) begin
         r_data[r_vic][r_set][r_beat] <= bus.mem_rdata;
         if (w_last) r_tag[r_vic][r_set] <= r_mtag;
      end
   end

`ifdef DCACHE_PERF_CNT_EN
   logic [31:0] r_hit_cnt;
   logic [31:0] r_miss_cnt;
   logic        r_fill_done;

   // The completion right after a refill is the tail of a miss, not a hit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hit_cnt   <= '0;
         r_miss_cnt  <= '0;
         r_fill_done <= 1'b0;
      end else begin
         r_fill_done <= (r_state == REFILL) && bus.mem_ack && w_last;
         if (w_miss && r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
         if (w_hit && !r_fill_done && r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
      end
   end

   assign o_hit_count  = r_hit_cnt;
   assign o_miss_count = r_miss_cnt;
`else
   assign o_hit_count  = '0;
   assign o_miss_count = '0;
`endif
endmodule

// File: tb/tb_dcache_2way_wb.sv
// tb_dcache_2way_wb: randomized check of dcache_2way_wb against a flat-memory and per-set recency model
module tb_dcache_2way_wb;
   localparam int W = 4;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] data;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;

   int n_chk = 0;
   int n_fail = 0;
   int stalls = 0;
   int stall_pct = 0;
   int n_hit = 0;
   int n_miss = 0;

   logic [31:0] mem_a [logic [31:0]];
   logic [31:0] ref_a [logic [31:0]];
   beat_t       exp_q [$];

   int          cnt [8];
   logic [31:0] t_m [8];
   logic [31:0] t_l [8];
   bit          d_m [8];
   bit          d_l [8];

   always #5 clk = ~clk;

   dcache_2way_wb_if bus ();

   dcache_2way_wb dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .o_hit_count  (hit_cnt),
      .o_miss_count (miss_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rd_mem(input logic [31:0] a);
      return mem_a.exists(a) ? mem_a[a] : (a ^ 32'hC0DE_0000);
   endfunction

   function automatic logic [31:0] rd_ref(input logic [31:0] a);
      return ref_a.exists(a) ? ref_a[a] : (a ^ 32'hC0DE_0000);
   endfunction

   // Reset throws away dirty cache contents, so the CPU view falls back to memory.
   task automatic model_reset();
      for (int s = 0; s < 8; s++) cnt[s] = 0;
      ref_a  = mem_a;
      n_hit  = 0;
      n_miss = 0;
      exp_q.delete();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      bus.cpu_req = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_mem_req", 32'(bus.mem_req), 0);
      check("rst_mem_we", 32'(bus.mem_we), 0);
      check("rst_ready", 32'(bus.cpu_ready), 0);
      check("rst_hit", 32'(bus.hit_out), 0);
      check("rst_hit_cnt", hit_cnt, 0);
      check("rst_miss_cnt", miss_cnt, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
   endtask

   task automatic check_cnt();
      logic [31:0] eh;
      logic [31:0] em;
      @(posedge clk);
      #1 bus.cpu_req = 1'b0;
      @(negedge clk);
      eh = 32'(n_hit);
      em = 32'(n_miss);
`ifndef DCACHE_PERF_CNT_EN
      eh = 0;
      em = 0;
`endif
      check("hit_count", hit_cnt, eh);
      check("miss_count", miss_cnt, em);
   endtask

   task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd);
      logic [31:0] tg;
      logic [31:0] tt;
      bit          dd;
      bit          hit;
      bit          hit_m;
      int          s;
      int          lat;
      int          n;
      beat_t       b;
      tg    = a >> 7;
      s     = int'((a >> 4) & 32'd7);
      hit_m = cnt[s] > 0 && t_m[s] == tg;
      hit   = hit_m || (cnt[s] == 2 && t_l[s] == tg);
      lat   = 0;
      if (!hit) begin
         lat = W + 1;
         if (cnt[s] == 2 && d_l[s]) begin
            lat += W;
            for (int i = 0; i < W; i++) begin
               b.addr = (t_l[s] << 7) | (32'(s) << 4) | (32'(i) << 2);
               b.we   = 1'b1;
               b.data = rd_ref(b.addr);
               exp_q.push_back(b);
            end
         end
         for (int i = 0; i < W; i++) begin
            b.addr = (tg << 7) | (32'(s) << 4) | (32'(i) << 2);
            b.we   = 1'b0;
            b.data = 0;
            exp_q.push_back(b);
         end
      end
      stalls = 0;
      @(posedge clk);
      #1;
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = we;
      bus.cpu_addr  = a;
      bus.cpu_wdata = wd;
      n = 0;
      forever begin
         @(negedge clk);
         if (n == 0) check("hit_out", 32'(bus.hit_out), 32'(hit));
         if (bus.cpu_ready || n > 400) break;
         n++;
      end
      check("ready", 32'(bus.cpu_ready), 1);
      check("latency", 32'(n), 32'(lat + stalls));
      if (!we) check("rdata", bus.cpu_rdata, rd_ref(a));
      check("beats_left", 32'(exp_q.size()), 0);
      if (hit) begin
         n_hit++;
         if (!hit_m) begin
            tt = t_m[s]; dd = d_m[s];
            t_m[s] = t_l[s]; d_m[s] = d_l[s];
            t_l[s] = tt; d_l[s] = dd;
         end
      end else begin
         n_miss++;
         t_l[s] = t_m[s]; d_l[s] = d_m[s];
         t_m[s] = tg; d_m[s] = 1'b0;
         if (cnt[s] < 2) cnt[s]++;
      end
      if (we) begin
         d_m[s]   = 1'b1;
         ref_a[a] = wd;
      end
   endtask

   // Memory responder: random back-pressure, spurious acks while idle, beat-by-beat checking.
   initial begin
      beat_t e;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (bus.mem_req === 1'b1 && $urandom_range(99) >= stall_pct) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = rd_mem(bus.mem_addr);
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else begin
               e.addr = ~bus.mem_addr;
               e.we   = ~bus.mem_we;
               e.data = 0;
            end
            check("beat_addr", bus.mem_addr, e.addr);
            check("beat_we", 32'(bus.mem_we), 32'(e.we));
            if (bus.mem_we) begin
               if (e.we) check("wb_data", bus.mem_wdata, e.data);
               mem_a[bus.mem_addr] = bus.mem_wdata;
            end
         end else begin
            if (bus.mem_req === 1'b1) begin
               stalls++;
               if (exp_q.size() > 0) check("hold_addr", bus.mem_addr, exp_q[0].addr);
            end
            bus.mem_ack = (bus.mem_req !== 1'b1) && ($urandom_range(3) == 0);
            bus.mem_rdata = $urandom;
         end
      end
   end

   initial begin
      logic [31:0] a;
      beat_t       b;
      bus.cpu_req   = 1'b0;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = '0;
      bus.cpu_wdata = '0;
      mem_a[32'h40] = 32'hA0;
      mem_a[32'h44] = 32'hA1;
      mem_a[32'h48] = 32'hA2;
      mem_a[32'h4C] = 32'hA3;
      do_reset();

      stall_pct = 0;
      access(1'b0, 32'h40, 0);
      access(1'b0, 32'h44, 0);
      check_cnt();
      access(1'b1, 32'h48, 32'hDEAD_BEEF);
      access(1'b0, 32'h48, 0);
      access(1'b0, 32'hC0, 0);
      access(1'b0, 32'h140, 0);
      access(1'b0, 32'h48, 0);

      stall_pct = 30;
      for (int i = 0; i < 250; i++) begin
         a = (32'($urandom_range(3)) << 7) | (32'($urandom_range(3)) << 4) | (32'($urandom_range(3)) << 2);
         access(1'($urandom_range(1)), a, $urandom);
      end
      check_cnt();

      stall_pct = 0;
      do_reset();
      for (int i = 0; i < W; i++) begin
         b.addr = 32'h1000 | (32'(i) << 2);
         b.we   = 1'b0;
         b.data = 0;
         exp_q.push_back(b);
      end
      @(posedge clk);
      #1;
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = 32'h1000;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
      check("abort_req", 32'(bus.mem_req), 1);
      check("abort_addr", bus.mem_addr, 32'h1008);
      rst_n = 1'b0;
      bus.cpu_req = 1'b0;
      #1;
      check("abort_req_drop", 32'(bus.mem_req), 0);
      check("abort_ready", 32'(bus.cpu_ready), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
      access(1'b0, 32'h1000, 0);
      access(1'b0, 32'h1004, 0);
      check_cnt();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/dcache_2way_wb.md
# dcache_2way_wb

Parametrised 2-way set-associative, write-back, write-allocate data cache between the CPU load/store path and the data memory. Generalises the set count, block size and data width of the first-generation lookup-only cache. Adds:
- dirty-line eviction,
- burst refill over a ready/ack memory handshake,
- per-set LRU replacement,
- a CPU stall signal.

## Interface
- `DATA_WIDTH`, 32, word width in bits (multiple of 8)
- `ADDR_WIDTH`, 32, byte address width
- `SETS`, 8, number of sets (power of two, ≥2)
- `WORDS`, 4, words per block (power of two, ≥2)
- Derived: `TAG_W = ADDR_WIDTH - log2(SETS) - log2(WORDS) - log2(DATA_WIDTH/8)`
- `clk`  in  1  clock
- `rst_n`  in  1  reset; one clock, asynchronous, active-low
- `cpu_req`  in  1  access request; held with addr/we/wdata stable until `cpu_ready`
- `cpu_we`  in  1  1 = store, 0 = load
- `cpu_addr`  in  ADDR_WIDTH  byte address (word aligned)
- `cpu_wdata`  in  DATA_WIDTH  store data
- `cpu_rdata`  out  DATA_WIDTH  load data, valid when `cpu_ready`
- `cpu_ready`  out  1  access completes this cycle
- `hit_out`  out  1  lookup hit this cycle
- `mem_req`  out  1  memory beat request
- `mem_we`  out  1  1 = writeback beat, 0 = refill beat
- `mem_addr`  out  ADDR_WIDTH  word address of current beat
- `mem_wdata`  out  DATA_WIDTH  writeback data
- `mem_rdata`  in  DATA_WIDTH  refill data, sampled with `mem_ack`
- `mem_ack`  in  1  beat accepted/complete this cycle
- `hit_count`  out  32  hit counter (see Configuration)
- `miss_count`  out  32  miss counter (see Configuration)

## Operation
- **Per-set state:**
  - two ways, each with valid, dirty, tag and `WORDS` data words;
  - one LRU bit naming the way to replace next.
- **Address split:** `[tag | set | word offset | byte offset]`.
- **FSM states:** `IDLE`, `WBACK`, `REFILL`.
- **IDLE:**
  - `hit_out = cpu_req & ((v0 & tag0==tag) | (v1 & tag1==tag))`, combinational; `cpu_ready = hit_out`.
  - Load hit: `cpu_rdata` is the selected word.
  - Store hit: word written and that way's dirty bit set at the edge.
  - Any hit: LRU points to the other way after the edge.
- **IDLE miss (`cpu_req & ~hit_out`):**
  - Victim choice: invalid way0, else invalid way1, else the LRU way.
  - Next state is `WBACK` if the victim is valid and dirty, otherwise `REFILL`.
  - The beat counter clears.
- **WBACK:**
  - `mem_req=1`, `mem_we=1`.
  - `mem_addr` = {victim tag, set, beat, 0}; `mem_wdata` = victim word[beat].
  - Beat advances on `mem_ack`.
  - On the last beat's ack: victim dirty cleared, go to `REFILL`.
- **REFILL:**
  - `mem_req=1`, `mem_we=0`, `mem_addr` = {cpu tag, set, beat, 0}.
  - On `mem_ack`, `mem_rdata` is written to victim word[beat].
  - On the last ack: victim valid=1, tag written, dirty=0, go to `IDLE`.
  - The held request then hits and completes as above; stores set dirty then.
- **Boundary conditions:**
  - `mem_ack` outside `WBACK`/`REFILL` is ignored.
  - Beats are never skipped or reordered; beat order is always 0..WORDS-1.
  - A line is marked valid only after its full refill.
  - `cpu_req` dropped mid-miss: the fill still completes; the line becomes valid.
- **Reset (asynchronous):**
  - All valid, dirty and LRU bits cleared; state = `IDLE`; counters = 0.
  - Data and tag arrays are not reset.
  - Reset mid-`WBACK`/`REFILL` aborts; the victim line stays as it was, except that an aborted refill leaves it invalid.

## Timing
- **Reset values:** `mem_req=0`, `mem_we=0`, `cpu_ready=0` (no request), `hit_out=0`, counters 0; `mem_addr`/`mem_wdata`/`cpu_rdata` don't-care.
- **Hit:** 0-cycle latency; `cpu_ready` in the request cycle.
- **Clean miss, `mem_ack` every cycle:** `cpu_ready` in cycle `WORDS+1` after the request cycle (cycle 0).
- **Dirty miss, `mem_ack` every cycle:** `cpu_ready` in cycle `2*WORDS+1`.
- **Memory back-pressure:** `mem_req`/`mem_addr`/`mem_we`/`mem_wdata` held stable until `mem_ack`; each ack-low cycle adds one cycle.
- **Back-to-back hits:** one access per cycle.

## Configuration
- **`DCACHE_PERF_CNT_EN` defined:**
  - `miss_count` +1 on each `IDLE` cycle that leaves `IDLE`.
  - `hit_count` +1 on each `cpu_ready` cycle not directly following a `REFILL` completion.
  - Both counters saturate at 0xFFFF_FFFF.
- **Undefined:** both outputs are tied to 0 and no counter registers exist.

## Test plan
- **Clean read miss then hit.** Defaults, reset, load 0x40; memory acks every cycle with 0xA0, 0xA1, 0xA2, 0xA3.
  - Refill beats at 0x40, 0x44, 0x48, 0x4C with `mem_we=0`.
  - `cpu_ready` in cycle 5, `cpu_rdata`=0xA0.
  - Load 0x44: same-cycle `cpu_ready`, `hit_out=1`, data 0xA1.
- **Store hit.** Store 0xDEADBEEF to 0x48: completes same cycle; load 0x48 returns 0xDEADBEEF.
- **Fill second way, then dirty eviction.** Load 0xC0, then load 0x140 (both set 4).
  - 0xC0 fills way1.
  - 0x140 evicts way0 (LRU): writeback beats 0x40..0x4C with `mem_we=1`, data 0xA0, 0xA1, 0xDEADBEEF, 0xA3.
  - Refill of 0x140 follows; `cpu_ready` in cycle 9.
- **Memory back-pressure.** `mem_ack` low for 3 cycles during refill beat 1: `mem_addr` held at beat 1; completion delayed by exactly 3 cycles.
- **Reset during refill.** `rst_n` low during refill beat 2: `mem_req` drops immediately; after release, load of the same address gives `hit_out=0` and a fresh refill.
- **Counters.** Scenario 1 with `DCACHE_PERF_CNT_EN`: `miss_count=1`, `hit_count=1`; without the macro both read 0.
